matrix_loader: RTL and testbench

Upstream feeder for the inverse_matrix engine. Accepts a row-major stream of N×N 32-bit matrix elements over a valid/ready handshake and holds them in an internal register file. Once a complete, correctly framed matrix is stored, it pulses `start` to the engine and serves element reads while the engine runs. Input stays stalled until the engine reports completion.

---
 rtl/matrix_loader.sv | 127 ++++++++++++
 tb/tb_matrix_loader.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_loader.sv
// Stream-in loader for the inverse_matrix engine: collects one framed N*N matrix,
// launches the engine with a start pulse and serves registered element reads.
module matrix_loader #(
  parameter int unsigned N  = 3,
  parameter int unsigned W  = 32,
  parameter int unsigned AW = $clog2(N*N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic          in_last,
  output logic          start,
  input  logic          eng_done,
  output logic          busy,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data,
  output logic          err_len,
  output logic [15:0]   frames
);

  localparam int unsigned NN = N * N;

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_FIRE = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic           in_ready_q, in_ready_d;
  logic           busy_q, busy_d;
  logic           start_q, start_d;

  logic [AW-1:0]  cnt_q, cnt_d;
  logic           err_q, err_d;
  logic [15:0]    frames_q, frames_d;
  logic [W-1:0]   rd_data_q, rd_data_d;
  logic [W-1:0]   mem_q [NN];

  logic           xfer;
  logic           at_end;
  logic           complete;
  logic           frame_err;

  assign xfer      = in_valid && (state_q == S_LOAD);
  assign at_end    = (cnt_q == AW'(NN - 1));
  assign complete  = xfer && at_end && in_last;
  assign frame_err = xfer && (in_last != at_end);

  // State register; handshake/status outputs are registered alongside it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_LOAD;
      in_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      start_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      start_q    <= start_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOAD:  if (complete) state_d = S_FIRE;
      S_FIRE:  state_d = S_WAIT;
      S_WAIT:  if (eng_done) state_d = S_LOAD;
      default: state_d = S_LOAD;
    endcase
  end

  // Outputs decoded from the upcoming state so they line up with it after the edge
  always_comb begin
    in_ready_d = 1'b0;
    busy_d     = 1'b1;
    start_d    = 1'b0;
    if (state_d == S_LOAD) begin
      in_ready_d = 1'b1;
      busy_d     = 1'b0;
    end
    if (state_d == S_FIRE) start_d = 1'b1;
  end

  // Element counter, sticky framing error, frame counter and read mux
  always_comb begin
    cnt_d    = cnt_q;
    err_d    = err_q;
    frames_d = frames_q;
    if (xfer) begin
      cnt_d = (at_end || in_last) ? '0 : cnt_q + AW'(1);
    end
    if (frame_err) err_d = 1'b1;
    if (state_q == S_FIRE) frames_d = frames_q + 16'd1;
    rd_data_d = (32'(rd_addr) < NN) ? mem_q[rd_addr] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      err_q     <= 1'b0;
      frames_q  <= '0;
      rd_data_q <= '0;
      for (int unsigned i = 0; i < NN; i++) mem_q[i] <= '0;
    end else begin
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      frames_q  <= frames_d;
      rd_data_q <= rd_data_d;
      // Erroneous elements are still written; the frame is simply never launched
      if (xfer) mem_q[cnt_q] <= in_data;
    end
  end

  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign start    = start_q;
  assign rd_data  = rd_data_q;
  assign err_len  = err_q;
  assign frames   = frames_q;

endmodule

// File: tb/tb_matrix_loader.sv
// Self-checking bench for matrix_loader: vector table, hand-written corner sequences
// and randomized framed traffic checked against a frame-level reference model.
module tb_matrix_loader;

  localparam int unsigned N  = 3;
  localparam int unsigned W  = 32;
  localparam int unsigned NN = N * N;
  localparam int unsigned AW = $clog2(NN);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          in_last;
  logic          start;
  logic          eng_done;
  logic          busy;
  logic [AW-1:0] rd_addr;
  logic [W-1:0]  rd_data;
  logic          err_len;
  logic [15:0]   frames;

  always #5 clk = ~clk;

  matrix_loader #(.N(N), .W(W), .AW(AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .start    (start),
    .eng_done (eng_done),
    .busy     (busy),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .err_len  (err_len),
    .frames   (frames)
  );

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic        exp_start;
    logic        exp_err;
    logic        exp_rdy;
  } vec_t;

  vec_t        vq[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_start = 0;
  logic [W-1:0] mmem [NN];
  int          midx;
  int          mframes;
  logic        fire;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (start === 1'b1) n_start++;
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(NN); i++) mmem[i] = '0;
    midx    = 0;
    mframes = 0;
  endtask

  // Frame-level model: an element lands at its running index; a frame launches only
  // when the last marker and the final index coincide, anything else restarts the frame
  task automatic model_accept(input logic [W-1:0] d, input logic last, output logic f);
    mmem[midx] = d;
    f = 1'b0;
    if (last || midx == int'(NN) - 1) begin
      if (last && midx == int'(NN) - 1) begin
        f = 1'b1;
        mframes++;
      end
      midx = 0;
    end else begin
      midx++;
    end
  endtask

  task automatic push(input logic [W-1:0] d, input logic last, output logic f);
    int waited = 0;
    f = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (in_ready !== 1'b1 && waited < 100) begin
      step();
      waited++;
    end
    if (waited >= 100) begin
      n_tests++;
      n_fail++;
      $display("FAIL push_timeout: in_ready stayed low for %0d cycles", waited);
    end else begin
      step();
      model_accept(d, last, f);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic read_all(input string tag);
    for (int a = 0; a < (1 << AW); a++) begin
      rd_addr = AW'(a);
      step();
      chk($sformatf("%s_rd%0d", tag, a), rd_data, (a < int'(NN)) ? mmem[a] : 32'd0);
    end
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    in_last  = 1'b0;
    eng_done = 1'b0;
    rd_addr  = '0;
    rst_n    = 1'b0;
    #12;
    rst_n = 1'b1;
    model_reset();
    step();
  endtask

  // Called right after the final element of a good frame was accepted
  task automatic finish_frame(input string tag);
    chk({tag, "_start_hi"}, 32'(start), 1);
    chk({tag, "_busy"}, 32'(busy), 1);
    chk({tag, "_ready_lo"}, 32'(in_ready), 0);
    step();
    chk({tag, "_start_lo"}, 32'(start), 0);
    chk({tag, "_frames"}, 32'(frames), 32'(mframes));
    read_all(tag);
    chk({tag, "_wait_ready"}, 32'(in_ready), 0);
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    chk({tag, "_done_ready"}, 32'(in_ready), 1);
    chk({tag, "_done_busy"}, 32'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
    eng_done = 1'b0;
    rd_addr  = '0;
    rst_n    = 1'b0;
    model_reset();
    #6;
    chk("rst_ready", 32'(in_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_start", 32'(start), 0);
    chk("rst_err", 32'(err_len), 0);
    chk("rst_frames", 32'(frames), 0);
    chk("rst_rd", rd_data, 0);
    #6;
    rst_n = 1'b1;
    step();

    // Vector table: clean frame, early last, clean frame with sticky error
    for (int i = 1; i <= 9; i++)
      vq.push_back('{data: 32'(i), last: (i == 9), exp_start: (i == 9), exp_err: 1'b0, exp_rdy: (i != 9)});
    for (int i = 0; i < 4; i++)
      vq.push_back('{data: 32'(32'h10 + i), last: (i == 3), exp_start: 1'b0, exp_err: (i == 3), exp_rdy: 1'b1});
    for (int i = 0; i < 9; i++)
      vq.push_back('{data: 32'(32'h20 + i), last: (i == 8), exp_start: (i == 8), exp_err: 1'b1, exp_rdy: (i != 8)});

    for (int k = 0; k < vq.size(); k++) begin
      push(vq[k].data, vq[k].last, fire);
      chk($sformatf("v%0d_start", k), 32'(start), 32'(vq[k].exp_start));
      chk($sformatf("v%0d_err", k), 32'(err_len), 32'(vq[k].exp_err));
      chk($sformatf("v%0d_ready", k), 32'(in_ready), 32'(vq[k].exp_rdy));
      if (vq[k].exp_start) finish_frame($sformatf("v%0d", k));
    end
    chk("tbl_err_sticky", 32'(err_len), 1);

    // Missing last on the 9th element: error, no launch, next element goes to mem[0]
    do_reset();
    s0 = n_start;
    for (int i = 0; i < 9; i++) begin
      push(32'(32'h30 + i), 1'b0, fire);
      chk($sformatf("miss%0d_err", i), 32'(err_len), (i == 8) ? 1 : 0);
      chk($sformatf("miss%0d_ready", i), 32'(in_ready), 1);
    end
    push(32'h40, 1'b0, fire);
    read_all("miss");
    chk("miss_no_start", 32'(n_start - s0), 0);
    chk("miss_busy", 32'(busy), 0);

    // Asynchronous reset after 5 elements
    do_reset();
    for (int i = 0; i < 5; i++) push(32'(32'h60 + i), 1'b0, fire);
    rd_addr = '0;
    step();
    chk("pre_rst_rd", rd_data, 32'h60);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst1_ready", 32'(in_ready), 1);
    chk("arst1_rd", rd_data, 0);
    chk("arst1_frames", 32'(frames), 0);
    model_reset();
    #10;
    rst_n = 1'b1;
    step();
    read_all("arst1");

    // Asynchronous reset during WAIT
    for (int i = 0; i < 9; i++) push(32'(32'h70 + i), (i == 8), fire);
    step();
    chk("wait_frames", 32'(frames), 1);
    chk("wait_busy", 32'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst2_ready", 32'(in_ready), 1);
    chk("arst2_busy", 32'(busy), 0);
    chk("arst2_start", 32'(start), 0);
    chk("arst2_frames", 32'(frames), 0);
    chk("arst2_rd", rd_data, 0);
    model_reset();
    #10;
    rst_n = 1'b1;
    step();
    read_all("arst2");

    // Randomized gaps across 3 matrices, engine completes 10 cycles after each start
    do_reset();
    s0 = n_start;
    for (int m = 0; m < 3; m++) begin
      for (int e = 0; e < int'(NN); e++) begin
        repeat ($urandom_range(0, 3)) step();
        push($urandom, (e == int'(NN) - 1), fire);
      end
      chk($sformatf("rnd%0d_start", m), 32'(start), 1);
      step();
      chk($sformatf("rnd%0d_start_1cyc", m), 32'(start), 0);
      repeat (8) step();
      eng_done = 1'b1;
      step();
      eng_done = 1'b0;
      read_all($sformatf("rnd%0d", m));
    end
    chk("rnd_starts", 32'(n_start - s0), 3);
    chk("rnd_frames", 32'(frames), 32'(mframes));
    chk("rnd_frames3", 32'(frames), 3);
    chk("rnd_err", 32'(err_len), 0);

    // Backpressure: word held during WAIT is accepted one cycle after eng_done
    for (int i = 0; i < 9; i++) push(32'(32'h50 + i), (i == 8), fire);
    step();
    rd_addr  = '0;
    in_valid = 1'b1;
    in_data  = 32'hDEADBEEF;
    in_last  = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      chk($sformatf("bp%0d_ready", c), 32'(in_ready), 0);
      chk($sformatf("bp%0d_mem0", c), rd_data, 32'h50);
    end
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    chk("bp_ready_after_done", 32'(in_ready), 1);
    chk("bp_mem0_old", rd_data, 32'h50);
    step();
    model_accept(32'hDEADBEEF, 1'b0, fire);
    in_valid = 1'b0;
    step();
    chk("bp_mem0_new", rd_data, 32'hDEADBEEF);
    read_all("bp");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
